// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with a 2-entry skid buffer and valid/ready handshake.
// The main entry drives the outputs; the skid entry absorbs one beat while downstream
// stalls, so ready_out can be registered without losing throughput.
// Optional statistics counters are built only when PIPE_STAGE_STATS_EN is defined;
// otherwise stall_cnt/flush_cnt are tied to zero.
module pipe_stage_reg #(
    parameter int unsigned       PC_W     = 32,
    parameter int unsigned       INST_W   = 32,
    parameter int unsigned       SIDE_W   = 8,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(32'h0000_0013),
    parameter int unsigned       CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic [PC_W-1:0]   pc_in,
    input  logic [INST_W-1:0] inst_in,
    input  logic [SIDE_W-1:0] side_in,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [PC_W-1:0]   pc_out,
    output logic [INST_W-1:0] inst_out,
    output logic [SIDE_W-1:0] side_out,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e            state_q;
    logic              ready_q;
    logic [PC_W-1:0]   main_pc_q, skid_pc_q;
    logic [INST_W-1:0] main_inst_q, skid_inst_q;
    logic [SIDE_W-1:0] main_side_q, skid_side_q;

    logic accept;
    logic emit;

    assign valid_out = (state_q != StEmpty);
    assign ready_out = ready_q;
    assign accept    = valid_in & ready_q;
    assign emit      = valid_out & ready_in;

    // Occupancy FSM plus entry storage; ready is registered from the next occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StEmpty;
            ready_q     <= 1'b1;
            main_pc_q   <= '0;
            main_inst_q <= NOP_INST;
            main_side_q <= '0;
            skid_pc_q   <= '0;
            skid_inst_q <= NOP_INST;
            skid_side_q <= '0;
        end else if (flush) begin
            // Dropping every entry and the incoming beat; payload registers are don't-care.
            state_q <= StEmpty;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (accept) begin
                        main_pc_q   <= pc_in;
                        main_inst_q <= inst_in;
                        main_side_q <= side_in;
                        state_q     <= StOne;
                    end
                    ready_q <= 1'b1;
                end
                StOne: begin
                    if (accept && emit) begin
                        main_pc_q   <= pc_in;
                        main_inst_q <= inst_in;
                        main_side_q <= side_in;
                        ready_q     <= 1'b1;
                    end else if (accept) begin
                        skid_pc_q   <= pc_in;
                        skid_inst_q <= inst_in;
                        skid_side_q <= side_in;
                        state_q     <= StFull;
                        ready_q     <= 1'b0;
                    end else if (emit) begin
                        state_q <= StEmpty;
                        ready_q <= 1'b1;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                StFull: begin
                    if (emit) begin
                        main_pc_q   <= skid_pc_q;
                        main_inst_q <= skid_inst_q;
                        main_side_q <= skid_side_q;
                        state_q     <= StOne;
                        ready_q     <= 1'b1;
                    end else begin
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StEmpty;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Head payload, forced to a NOP bubble whenever no entry is valid.
    always_comb begin
        pc_out   = '0;
        inst_out = NOP_INST;
        side_out = '0;
        if (valid_out) begin
            pc_out   = main_pc_q;
            inst_out = main_inst_q;
            side_out = main_side_q;
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic             flush_kill;

    // A flush only counts when it actually discards a held entry or an offered beat.
    assign flush_kill = flush & (valid_out | valid_in);

    // Saturating event counters, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (valid_out && !ready_in && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (flush_kill && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios followed by random traffic,
// all compared against a queue-based reference model of the stage.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        valid_in = 1'b0;
    logic        ready_in = 1'b0;
    logic [31:0] pc_in = '0;
    logic [31:0] inst_in = '0;
    logic [7:0]  side_in = '0;

    logic        ready_out, valid_out;
    logic [31:0] pc_out, inst_out;
    logic [7:0]  side_out;
    logic [15:0] stall_cnt, flush_cnt;

    logic        ready_out4, valid_out4;
    logic [31:0] pc_out4, inst_out4;
    logic [7:0]  side_out4;
    logic [3:0]  stall_cnt4, flush_cnt4;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk(clk), .rst(rst), .flush(flush), .valid_in(valid_in), .ready_out(ready_out),
        .pc_in(pc_in), .inst_in(inst_in), .side_in(side_in), .valid_out(valid_out),
        .ready_in(ready_in), .pc_out(pc_out), .inst_out(inst_out), .side_out(side_out),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation.
    pipe_stage_reg #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush), .valid_in(valid_in), .ready_out(ready_out4),
        .pc_in(pc_in), .inst_in(inst_in), .side_in(side_in), .valid_out(valid_out4),
        .ready_in(ready_in), .pc_out(pc_out4), .inst_out(inst_out4), .side_out(side_out4),
        .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [7:0]  side;
    } beat_t;

    beat_t       q[$];
    logic [15:0] stall_exp = '0;
    logic [15:0] flush_exp = '0;
    logic [3:0]  stall4_exp = '0;
    logic [3:0]  flush4_exp = '0;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: a FIFO of at most two beats, advanced once per clock edge.
    task automatic model_update();
        int    n;
        bit    acc, em;
        beat_t b;
        n   = q.size();
        acc = valid_in && (n < 2);
        em  = (n > 0) && ready_in;
        if (rst) begin
            q.delete();
            stall_exp  = '0;
            flush_exp  = '0;
            stall4_exp = '0;
            flush4_exp = '0;
        end else begin
            if (n > 0 && !ready_in) begin
                if (stall_exp != 16'hFFFF) stall_exp++;
                if (stall4_exp != 4'hF) stall4_exp++;
            end
            if (flush && (n > 0 || valid_in)) begin
                if (flush_exp != 16'hFFFF) flush_exp++;
                if (flush4_exp != 4'hF) flush4_exp++;
            end
            if (flush) begin
                q.delete();
            end else begin
                if (em) void'(q.pop_front());
                if (acc) begin
                    b.pc   = pc_in;
                    b.inst = inst_in;
                    b.side = side_in;
                    q.push_back(b);
                end
            end
        end
    endtask

    task automatic check_outputs();
        bit          v;
        logic [31:0] epc, einst;
        logic [7:0]  eside;
        v     = (q.size() > 0);
        epc   = v ? q[0].pc : 32'h0;
        einst = v ? q[0].inst : 32'h13;
        eside = v ? q[0].side : 8'h0;
        check_eq("valid_out", 64'(valid_out), 64'(v));
        check_eq("ready_out", 64'(ready_out), 64'(q.size() < 2));
        check_eq("pc_out", 64'(pc_out), 64'(epc));
        check_eq("inst_out", 64'(inst_out), 64'(einst));
        check_eq("side_out", 64'(side_out), 64'(eside));
        check_eq("pc_out4", 64'(pc_out4), 64'(epc));
`ifdef PIPE_STAGE_STATS_EN
        check_eq("stall_cnt", 64'(stall_cnt), 64'(stall_exp));
        check_eq("flush_cnt", 64'(flush_cnt), 64'(flush_exp));
        check_eq("stall_cnt4", 64'(stall_cnt4), 64'(stall4_exp));
        check_eq("flush_cnt4", 64'(flush_cnt4), 64'(flush4_exp));
`else
        check_eq("stall_cnt", 64'(stall_cnt), 64'(0));
        check_eq("flush_cnt", 64'(flush_cnt), 64'(0));
        check_eq("stall_cnt4", 64'(stall_cnt4), 64'(0));
        check_eq("flush_cnt4", 64'(flush_cnt4), 64'(0));
`endif
    endtask

    // Apply one cycle of inputs, advance the model and check just after the edge.
    task automatic step(input logic v, input logic [31:0] pc, input logic rdy,
                        input logic fl, input logic rs);
        valid_in = v;
        pc_in    = pc;
        inst_in  = $urandom;
        side_in  = 8'($urandom);
        ready_in = rdy;
        flush    = fl;
        rst      = rs;
        model_update();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        // Reset for two cycles.
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        check_eq("reset_inst_nop", 64'(inst_out), 64'(32'h13));

        // Back-to-back stream of 8 beats with downstream always ready.
        for (int i = 0; i < 8; i++) step(1'b1, 32'(i * 4), 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Skid: A emitted-stalled, B fills the skid, hold, then drain.
        step(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h104, 1'b0, 1'b0, 1'b0);
        check_eq("skid_full_ready", 64'(ready_out), 64'(0));
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Flush while full with a beat C offered.
        step(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h104, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h108, 1'b0, 1'b1, 1'b0);
        check_eq("flush_bubble_valid", 64'(valid_out), 64'(0));
        // Flush when empty and idle changes nothing.
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Long stall to push the narrow counter into saturation.
        step(1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a full stage.
        step(1'b1, 32'h204, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        check_eq("rst_mid_full_ready", 64'(ready_out), 64'(1));

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 9) < 7), $urandom, ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 99) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
